// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one main-memory port between an icache fill path
// and a dcache fill/write-back path. Each transaction is latched into holding
// registers at grant time, so requester inputs may change once a grant starts.
// A grant completes when main memory has asserted busy and then released it.
// Optional build macro ARB_ROUND_ROBIN_EN: on a tie, the requester that was
// not served last wins. When it is undefined, dcache always wins a tie.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W = 28,
  parameter int unsigned LINE_W = 128
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              I_MEM_READ,
  input  logic [ADDR_W-1:0] I_MEM_ADDRESS,
  output logic [LINE_W-1:0] I_MEM_READ_DATA,
  output logic              I_MEM_BUSY_WAIT,
  input  logic              D_MEM_READ,
  input  logic              D_MEM_WRITE,
  input  logic [ADDR_W-1:0] D_MEM_ADDRESS,
  input  logic [LINE_W-1:0] D_MEM_WRITE_DATA,
  output logic [LINE_W-1:0] D_MEM_READ_DATA,
  output logic              D_MEM_BUSY_WAIT,
  output logic              MAIN_MEM_READ,
  output logic              MAIN_MEM_WRITE,
  output logic [ADDR_W-1:0] MAIN_MEM_ADDRESS,
  output logic [LINE_W-1:0] MAIN_MEM_WRITE_DATA,
  input  logic [LINE_W-1:0] MAIN_MEM_READ_DATA,
  input  logic              MAIN_MEM_BUSY_WAIT
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GRANT_I = 3'd1,
    GRANT_D = 3'd2,
    DONE_I  = 3'd3,
    DONE_D  = 3'd4
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic              i_req;
  logic              d_req;
  logic              pick_d;
  logic              grant_c;
  logic              complete_c;
  logic              seen_busy_q;
  logic              main_read_q;
  logic              main_write_q;
  logic [ADDR_W-1:0] main_addr_q;
  logic [LINE_W-1:0] main_wdata_q;
  logic [LINE_W-1:0] i_rdata_q;
  logic [LINE_W-1:0] d_rdata_q;

  assign i_req = I_MEM_READ;
  assign d_req = D_MEM_READ | D_MEM_WRITE;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_d_q;

  // Tie goes to whichever requester was not granted most recently
  assign pick_d = d_req & (~i_req | ~last_d_q);

  // Remember the most recent winner; reset as if dcache was served last
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      last_d_q <= 1'b1;
    end else if (grant_c) begin
      last_d_q <= pick_d;
    end
  end
`else
  // Fixed priority: dcache wins any tie
  assign pick_d = d_req;
`endif

  // State register
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_req || d_req) state_d = pick_d ? GRANT_D : GRANT_I;
      GRANT_I: if (seen_busy_q && !MAIN_MEM_BUSY_WAIT) state_d = DONE_I;
      GRANT_D: if (seen_busy_q && !MAIN_MEM_BUSY_WAIT) state_d = DONE_D;
      DONE_I:  state_d = IDLE;
      DONE_D:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and strobe logic; busy drops only in the requester's DONE cycle
  always_comb begin
    grant_c         = 1'b0;
    complete_c      = 1'b0;
    I_MEM_BUSY_WAIT = 1'b0;
    D_MEM_BUSY_WAIT = 1'b0;
    if (state_q == IDLE) begin
      grant_c = i_req | d_req;
    end
    if ((state_q == GRANT_I) || (state_q == GRANT_D)) begin
      complete_c = seen_busy_q & ~MAIN_MEM_BUSY_WAIT;
    end
    if (RESET_N) begin
      I_MEM_BUSY_WAIT = i_req & (state_q != DONE_I);
      D_MEM_BUSY_WAIT = d_req & (state_q != DONE_D);
    end
  end

  // Holding registers, busy tracking and read-data capture
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      seen_busy_q  <= 1'b0;
      main_read_q  <= 1'b0;
      main_write_q <= 1'b0;
      main_addr_q  <= '0;
      main_wdata_q <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else if (grant_c) begin
      seen_busy_q <= 1'b0;
      if (pick_d) begin
        main_read_q  <= D_MEM_READ & ~D_MEM_WRITE;
        main_write_q <= D_MEM_WRITE;
        main_addr_q  <= D_MEM_ADDRESS;
        main_wdata_q <= D_MEM_WRITE_DATA;
      end else begin
        main_read_q  <= 1'b1;
        main_write_q <= 1'b0;
        main_addr_q  <= I_MEM_ADDRESS;
        main_wdata_q <= '0;
      end
    end else if (complete_c) begin
      main_read_q  <= 1'b0;
      main_write_q <= 1'b0;
      if (state_q == GRANT_I) begin
        i_rdata_q <= MAIN_MEM_READ_DATA;
      end else if (main_read_q) begin
        d_rdata_q <= MAIN_MEM_READ_DATA;
      end
    end else if (((state_q == GRANT_I) || (state_q == GRANT_D)) && MAIN_MEM_BUSY_WAIT) begin
      seen_busy_q <= 1'b1;
    end
  end

  assign MAIN_MEM_READ       = main_read_q;
  assign MAIN_MEM_WRITE      = main_write_q;
  assign MAIN_MEM_ADDRESS    = main_addr_q;
  assign MAIN_MEM_WRITE_DATA = main_wdata_q;
  assign I_MEM_READ_DATA     = i_rdata_q;
  assign D_MEM_READ_DATA     = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a busy-wait main-memory model, a transaction-level
// reference model that predicts grant order and returned lines, and scoreboard
// monitors on the main-memory side and on each requester side.
module tb_mem_port_arbiter;
  localparam int unsigned AW    = 28;
  localparam int unsigned LW    = 128;
  localparam int unsigned NLINE = 4096;

  logic          CLK = 1'b0;
  logic          RESET_N;
  logic          I_MEM_READ;
  logic [AW-1:0] I_MEM_ADDRESS;
  logic [LW-1:0] I_MEM_READ_DATA;
  logic          I_MEM_BUSY_WAIT;
  logic          D_MEM_READ;
  logic          D_MEM_WRITE;
  logic [AW-1:0] D_MEM_ADDRESS;
  logic [LW-1:0] D_MEM_WRITE_DATA;
  logic [LW-1:0] D_MEM_READ_DATA;
  logic          D_MEM_BUSY_WAIT;
  logic          MAIN_MEM_READ;
  logic          MAIN_MEM_WRITE;
  logic [AW-1:0] MAIN_MEM_ADDRESS;
  logic [LW-1:0] MAIN_MEM_WRITE_DATA;
  logic [LW-1:0] MAIN_MEM_READ_DATA;
  logic          MAIN_MEM_BUSY_WAIT;

  mem_port_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .CLK                 (CLK),
    .RESET_N             (RESET_N),
    .I_MEM_READ          (I_MEM_READ),
    .I_MEM_ADDRESS       (I_MEM_ADDRESS),
    .I_MEM_READ_DATA     (I_MEM_READ_DATA),
    .I_MEM_BUSY_WAIT     (I_MEM_BUSY_WAIT),
    .D_MEM_READ          (D_MEM_READ),
    .D_MEM_WRITE         (D_MEM_WRITE),
    .D_MEM_ADDRESS       (D_MEM_ADDRESS),
    .D_MEM_WRITE_DATA    (D_MEM_WRITE_DATA),
    .D_MEM_READ_DATA     (D_MEM_READ_DATA),
    .D_MEM_BUSY_WAIT     (D_MEM_BUSY_WAIT),
    .MAIN_MEM_READ       (MAIN_MEM_READ),
    .MAIN_MEM_WRITE      (MAIN_MEM_WRITE),
    .MAIN_MEM_ADDRESS    (MAIN_MEM_ADDRESS),
    .MAIN_MEM_WRITE_DATA (MAIN_MEM_WRITE_DATA),
    .MAIN_MEM_READ_DATA  (MAIN_MEM_READ_DATA),
    .MAIN_MEM_BUSY_WAIT  (MAIN_MEM_BUSY_WAIT)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
  } mtx_t;

  int vectors     = 0;
  int miscompares = 0;

  mtx_t          exp_main_q[$];
  logic [LW-1:0] exp_i_q[$];
  logic [LW-1:0] exp_d_q[$];

  // Reference model state
  logic [LW-1:0] ref_mem [NLINE];
  logic [LW-1:0] ref_i_data;
  logic [LW-1:0] ref_d_data;
`ifdef ARB_ROUND_ROBIN_EN
  bit            model_last_d;
`endif

  function automatic logic [LW-1:0] init_line(input logic [AW-1:0] a);
    return {4{{4'h0, a} ^ 32'h5A5A_0000}};
  endfunction

  // Main memory: 4K lines aliased on the low address bits, busy for mem_lat cycles
  logic [LW-1:0] env_mem [NLINE];
  int unsigned   mem_lat = 1;
  logic          mm_active;
  int unsigned   mm_cnt;

  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      MAIN_MEM_BUSY_WAIT <= 1'b0;
      MAIN_MEM_READ_DATA <= '0;
      mm_active          <= 1'b0;
      mm_cnt             <= 0;
      for (int i = 0; i < NLINE; i++) env_mem[i] <= init_line(AW'(i));
    end else if (!mm_active) begin
      if (MAIN_MEM_READ || MAIN_MEM_WRITE) begin
        mm_active          <= 1'b1;
        MAIN_MEM_BUSY_WAIT <= 1'b1;
        mm_cnt             <= mem_lat - 1;
      end
    end else if (MAIN_MEM_BUSY_WAIT) begin
      if (mm_cnt == 0) begin
        MAIN_MEM_BUSY_WAIT <= 1'b0;
        if (MAIN_MEM_WRITE) env_mem[MAIN_MEM_ADDRESS[11:0]] <= MAIN_MEM_WRITE_DATA;
        else MAIN_MEM_READ_DATA <= env_mem[MAIN_MEM_ADDRESS[11:0]];
      end else begin
        mm_cnt <= mm_cnt - 1;
      end
    end else begin
      mm_active <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic finish_tb();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NLINE; i++) ref_mem[i] = init_line(AW'(i));
    ref_i_data = '0;
    ref_d_data = '0;
`ifdef ARB_ROUND_ROBIN_EN
    model_last_d = 1'b1;
`endif
  endtask

  task automatic serve_i(input logic [AW-1:0] ia);
    exp_main_q.push_back('{rd: 1'b1, wr: 1'b0, addr: ia, wdata: '0});
    ref_i_data = ref_mem[ia[11:0]];
    exp_i_q.push_back(ref_i_data);
`ifdef ARB_ROUND_ROBIN_EN
    model_last_d = 1'b0;
`endif
  endtask

  task automatic serve_d(input logic [AW-1:0] da, input logic drd, input logic dwr,
                         input logic [LW-1:0] dwd, input bit drop);
    exp_main_q.push_back('{rd: drd & ~dwr, wr: dwr, addr: da, wdata: dwd});
    if (dwr) ref_mem[da[11:0]] = dwd;
    else ref_d_data = ref_mem[da[11:0]];
    if (!drop) exp_d_q.push_back(ref_d_data);
`ifdef ARB_ROUND_ROBIN_EN
    model_last_d = 1'b1;
`endif
  endtask

  function automatic bit tie_to_i();
`ifdef ARB_ROUND_ROBIN_EN
    return model_last_d;
`else
    return 1'b0;
`endif
  endfunction

  // Main-side monitor: check each new transaction against the predicted order
  initial begin
    mtx_t cur;
    bit   act;
    act = 1'b0;
    cur = '0;
    forever begin
      @(negedge CLK);
      if (!RESET_N) begin
        act = 1'b0;
      end else if ((MAIN_MEM_READ || MAIN_MEM_WRITE) && !act) begin
        act = 1'b1;
        cur = '{rd: MAIN_MEM_READ, wr: MAIN_MEM_WRITE, addr: MAIN_MEM_ADDRESS, wdata: MAIN_MEM_WRITE_DATA};
        if (exp_main_q.size() == 0) begin
          chk("main_unexpected_txn", LW'(1), LW'(0));
        end else begin
          mtx_t e;
          e = exp_main_q.pop_front();
          chk("main_rd", LW'(cur.rd), LW'(e.rd));
          chk("main_wr", LW'(cur.wr), LW'(e.wr));
          chk("main_addr", LW'(cur.addr), LW'(e.addr));
          if (e.wr) chk("main_wdata", cur.wdata, e.wdata);
        end
      end else if (act && (MAIN_MEM_READ || MAIN_MEM_WRITE)) begin
        chk("main_addr_hold", LW'(MAIN_MEM_ADDRESS), LW'(cur.addr));
        if (cur.wr) chk("main_wdata_hold", MAIN_MEM_WRITE_DATA, cur.wdata);
      end else if (act) begin
        act = 1'b0;
      end
    end
  end

  // Requester-side monitors: every low busy with a live request is one response
  initial begin
    forever begin
      @(negedge CLK);
      if (RESET_N) begin
        if (I_MEM_READ && !I_MEM_BUSY_WAIT) begin
          if (exp_i_q.size() == 0) chk("i_unexpected_resp", LW'(1), LW'(0));
          else chk("i_read_data", I_MEM_READ_DATA, exp_i_q.pop_front());
        end
        if ((D_MEM_READ || D_MEM_WRITE) && !D_MEM_BUSY_WAIT) begin
          if (exp_d_q.size() == 0) chk("d_unexpected_resp", LW'(1), LW'(0));
          else chk("d_read_data", D_MEM_READ_DATA, exp_d_q.pop_front());
        end
        if (!I_MEM_READ && I_MEM_BUSY_WAIT) chk("i_busy_no_req", LW'(I_MEM_BUSY_WAIT), LW'(0));
        if (!(D_MEM_READ || D_MEM_WRITE) && D_MEM_BUSY_WAIT) chk("d_busy_no_req", LW'(D_MEM_BUSY_WAIT), LW'(0));
      end
    end
  end

  // One scenario: raise the chosen requests together, hold each until served
  task automatic run_scn(input bit use_i, input bit use_d, input logic [AW-1:0] ia,
                         input logic [AW-1:0] da, input logic drd, input logic dwr,
                         input logic [LW-1:0] dwd, input int unsigned lat,
                         input int unsigned scr, input bit drop_d);
    bit i_done;
    bit d_done;
    int cyc;
    mem_lat = lat;
    if (use_i && (!use_d || tie_to_i())) begin
      serve_i(ia);
      if (use_d) serve_d(da, drd, dwr, dwd, drop_d);
    end else begin
      if (use_d) serve_d(da, drd, dwr, dwd, drop_d);
      if (use_i) serve_i(ia);
    end
    @(posedge CLK); #1;
    I_MEM_READ       = use_i;
    I_MEM_ADDRESS    = ia;
    D_MEM_READ       = use_d & drd;
    D_MEM_WRITE      = use_d & dwr;
    D_MEM_ADDRESS    = da;
    D_MEM_WRITE_DATA = dwd;
    i_done = !use_i;
    d_done = !use_d;
    cyc    = 0;
    while (!(i_done && d_done)) begin
      @(negedge CLK);
      if (!i_done && !I_MEM_BUSY_WAIT) i_done = 1'b1;
      if (!d_done && !drop_d && !D_MEM_BUSY_WAIT) d_done = 1'b1;
      @(posedge CLK); #1;
      if (i_done) I_MEM_READ = 1'b0;
      if (d_done || (drop_d && cyc == 1)) begin
        D_MEM_READ  = 1'b0;
        D_MEM_WRITE = 1'b0;
        d_done      = 1'b1;
      end
      if (scr == 1) begin
        D_MEM_ADDRESS = AW'(28'hFFF);
      end else if (scr == 2) begin
        I_MEM_ADDRESS    = AW'($urandom);
        D_MEM_ADDRESS    = AW'($urandom);
        D_MEM_WRITE_DATA = {$urandom, $urandom, $urandom, $urandom};
      end
      cyc++;
      if (cyc > 200) begin
        chk("request_timeout", LW'(cyc), LW'(200));
        finish_tb();
      end
    end
    cyc = 0;
    while ((MAIN_MEM_READ || MAIN_MEM_WRITE || MAIN_MEM_BUSY_WAIT || mm_active) && cyc < 100) begin
      @(posedge CLK);
      cyc++;
    end
    if (cyc >= 100) begin
      chk("main_idle_timeout", LW'(cyc), LW'(0));
      finish_tb();
    end
    repeat (2) @(posedge CLK);
    #1;
    chk("i_data_held", I_MEM_READ_DATA, ref_i_data);
    chk("d_data_held", D_MEM_READ_DATA, ref_d_data);
    chk("i_resp_all_seen", LW'(exp_i_q.size()), LW'(0));
    chk("d_resp_all_seen", LW'(exp_d_q.size()), LW'(0));
  endtask

  initial begin
    logic [LW-1:0] a5_line;
    a5_line = {16{8'hA5}};
    model_reset();
    RESET_N          = 1'b0;
    I_MEM_READ       = 1'b1;
    I_MEM_ADDRESS    = '0;
    D_MEM_READ       = 1'b1;
    D_MEM_WRITE      = 1'b0;
    D_MEM_ADDRESS    = '0;
    D_MEM_WRITE_DATA = '0;
    #12;
    chk("rst_i_busy", LW'(I_MEM_BUSY_WAIT), LW'(0));
    chk("rst_d_busy", LW'(D_MEM_BUSY_WAIT), LW'(0));
    chk("rst_main_read", LW'(MAIN_MEM_READ), LW'(0));
    chk("rst_main_write", LW'(MAIN_MEM_WRITE), LW'(0));
    chk("rst_main_addr", LW'(MAIN_MEM_ADDRESS), LW'(0));
    chk("rst_main_wdata", MAIN_MEM_WRITE_DATA, LW'(0));
    chk("rst_i_data", I_MEM_READ_DATA, LW'(0));
    chk("rst_d_data", D_MEM_READ_DATA, LW'(0));
    I_MEM_READ = 1'b0;
    D_MEM_READ = 1'b0;
    @(posedge CLK); #1;
    RESET_N = 1'b1;

    // Lone icache read of a line holding A5 pattern, memory busy 3 cycles
    run_scn(0, 1, '0, AW'(28'h10), 1'b0, 1'b1, a5_line, 2, 0, 0);
    run_scn(1, 0, AW'(28'h10), '0, 1'b0, 1'b0, '0, 3, 0, 0);
    chk("i_a5_line", I_MEM_READ_DATA, a5_line);

    // Simultaneous icache and dcache reads
    run_scn(1, 1, AW'(28'h20), AW'(28'h30), 1'b1, 1'b0, '0, 2, 0, 0);

    // Write-back then fill, and read+write treated as write
    run_scn(0, 1, '0, AW'(28'h123), 1'b0, 1'b1, {32{4'h1}}, 2, 0, 0);
    run_scn(0, 1, '0, AW'(28'h456), 1'b1, 1'b0, '0, 2, 0, 0);
    run_scn(0, 1, '0, AW'(28'h124), 1'b1, 1'b1, {32{4'h7}}, 1, 0, 0);
    run_scn(0, 1, '0, AW'(28'h124), 1'b1, 1'b0, '0, 1, 0, 0);

    // Address changes during a grant are ignored
    run_scn(0, 1, '0, AW'(28'h1), 1'b1, 1'b0, '0, 4, 1, 0);

    // Back-to-back ties
    run_scn(1, 1, AW'(28'h40), AW'(28'h50), 1'b1, 1'b0, '0, 1, 0, 0);
    run_scn(1, 1, AW'(28'h41), AW'(28'h51), 1'b1, 1'b0, '0, 1, 0, 0);

    // Dcache drops its request mid-grant; read is still captured
    run_scn(0, 1, '0, AW'(28'h60), 1'b1, 1'b0, '0, 3, 0, 1);

    // Randomized scenarios
    for (int n = 0; n < 80; n++) begin
      int unsigned kind;
      int unsigned op;
      int unsigned scr;
      bit          drop;
      kind = $urandom_range(0, 2);
      op   = $urandom_range(0, 2);
      scr  = (kind != 2 && $urandom_range(0, 1) == 1) ? 2 : 0;
      drop = (kind == 1 && $urandom_range(0, 7) == 0);
      run_scn(kind != 1, kind != 0, AW'($urandom_range(0, 63)), AW'($urandom_range(0, 63)),
              op != 1, op != 0, {$urandom, $urandom, $urandom, $urandom},
              $urandom_range(1, 4), scr, drop);
    end

    // Reset in the middle of a dcache grant
    run_scn(0, 1, '0, AW'(28'h77), 1'b1, 1'b0, '0, 1, 0, 0);
    mem_lat = 10;
    exp_main_q.push_back('{rd: 1'b1, wr: 1'b0, addr: AW'(28'h777), wdata: '0});
    @(posedge CLK); #1;
    D_MEM_READ    = 1'b1;
    D_MEM_ADDRESS = AW'(28'h777);
    repeat (3) @(posedge CLK);
    #1;
    I_MEM_READ    = 1'b1;
    I_MEM_ADDRESS = AW'(28'h5);
    #2;
    chk("pre_rst_main_read", LW'(MAIN_MEM_READ), LW'(1));
    RESET_N = 1'b0;
    #1;
    chk("mid_rst_main_read", LW'(MAIN_MEM_READ), LW'(0));
    chk("mid_rst_main_write", LW'(MAIN_MEM_WRITE), LW'(0));
    chk("mid_rst_i_busy", LW'(I_MEM_BUSY_WAIT), LW'(0));
    chk("mid_rst_d_busy", LW'(D_MEM_BUSY_WAIT), LW'(0));
    I_MEM_READ = 1'b0;
    D_MEM_READ = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    RESET_N = 1'b1;
    @(posedge CLK); #1;
    chk("post_rst_d_data", D_MEM_READ_DATA, LW'(0));
    chk("post_rst_i_data", I_MEM_READ_DATA, LW'(0));
    chk("post_rst_main_addr", LW'(MAIN_MEM_ADDRESS), LW'(0));
    chk("post_rst_main_read", LW'(MAIN_MEM_READ), LW'(0));
    chk("post_rst_main_q", LW'(exp_main_q.size()), LW'(0));

    // Arbiter resumes normally after reset
    run_scn(1, 1, AW'(28'h8), AW'(28'h9), 1'b1, 1'b0, '0, 2, 0, 0);
    chk("end_main_q_empty", LW'(exp_main_q.size()), LW'(0));
    finish_tb();
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: ADDR_W, 28, block address width (tag+index, 16-byte line).
REQ-002 Parameter: LINE_W, 128, cache line width in bits.
REQ-003 Port: CLK  in  1  single clock, all state updates on rising edge.
REQ-004 Port: RESET_N  in  1  reset, asynchronous, active-low.
REQ-005 Port: I_MEM_READ  in  1  icache line-fill request.
REQ-006 Port: I_MEM_ADDRESS  in  ADDR_W  icache line address.
REQ-007 Port: I_MEM_READ_DATA  out  LINE_W  line returned to icache.
REQ-008 Port: I_MEM_BUSY_WAIT  out  1  icache stall.
REQ-009 Port: D_MEM_READ / D_MEM_WRITE  in  1 each  dcache fill / write-back request.
REQ-010 Port: D_MEM_ADDRESS  in  ADDR_W; D_MEM_WRITE_DATA  in  LINE_W  dcache address / write-back line.
REQ-011 Port: D_MEM_READ_DATA  out  LINE_W; D_MEM_BUSY_WAIT  out  1  dcache line / stall.
REQ-012 Port: MAIN_MEM_READ, MAIN_MEM_WRITE  out  1 each; MAIN_MEM_ADDRESS  out  ADDR_W; MAIN_MEM_WRITE_DATA  out  LINE_W  shared main-memory request.
REQ-013 Port: MAIN_MEM_READ_DATA  in  LINE_W; MAIN_MEM_BUSY_WAIT  in  1  main-memory response.

Function
REQ-014 FSM states SHALL be IDLE, GRANT_I, GRANT_D, DONE_I, DONE_D.
REQ-015 IDLE, rising edge: if a request is pending, pick a winner (REQ-024), latch its address, write data and operation into holding registers, and go to GRANT_x. Otherwise stay in IDLE.
REQ-016 A dcache request with both D_MEM_READ and D_MEM_WRITE high SHALL be treated as a write.
REQ-017 In GRANT_x, the MAIN_MEM_* outputs SHALL be driven only from the holding registers. Requester input changes during the grant SHALL be ignored.
REQ-018 A seen_busy flag SHALL clear on grant entry and set at any edge in GRANT_x with MAIN_MEM_BUSY_WAIT=1.
REQ-019 Completion is the first edge in GRANT_x with seen_busy=1 and MAIN_MEM_BUSY_WAIT=0. At that edge:
- capture MAIN_MEM_READ_DATA into the winner's read-data register (reads only);
- drop MAIN_MEM_READ/WRITE;
- go to DONE_x.
REQ-020 DONE_x SHALL last exactly one cycle, then return to IDLE. The loser's request stays pending and is granted from IDLE.
REQ-021 x_MEM_BUSY_WAIT = x request asserted AND state != DONE_x. The busy output is therefore low for exactly one cycle per completed transaction.
REQ-022 x_MEM_READ_DATA SHALL hold its last captured line until the next completed read for that requester.
REQ-023 Latency: request visible at edge N with the arbiter IDLE gives main request asserted from N, and busy low in the cycle after completion edge M. Minimum M = N+2.
REQ-024 Arbitration: a single requester always wins. On a tie, the winner is set by REQ-029.
REQ-025 A requester that drops its request mid-grant SHALL NOT abort the transaction. It completes and the result is discarded for the bus, but the read data is still captured.
REQ-026 A request still asserted during DONE_x SHALL be treated as a new request in the following IDLE.

Reset
REQ-027 When RESET_N=0, asynchronously:
- state = IDLE; seen_busy = 0;
- MAIN_MEM_READ/WRITE = 0; MAIN_MEM_ADDRESS = 0; MAIN_MEM_WRITE_DATA = 0;
- both read-data registers = 0; both BUSY_WAIT outputs forced 0;
- last-grant register = D.
REQ-028 Reset mid-transaction SHALL abandon it with no capture. Main memory is reset on the same RESET_N.

Configuration
REQ-029 Macro ARB_ROUND_ROBIN_EN:
- defined: a tie goes to the requester not served last; the last-grant register updates at each grant;
- undefined: a tie always goes to dcache; the last-grant register is omitted.

Verification
REQ-030 Lone icache read, addr 0x0000010, memory busy 3 cycles, returns 0xA5...A5 -> exactly one I_MEM_BUSY_WAIT low cycle with I_MEM_READ_DATA=0xA5...A5; D_MEM_BUSY_WAIT stays 0.
REQ-031 I and D read requests at the same edge -> macro undefined: D granted first, then I; macro defined: I first (reset last=D), then D.
REQ-032 Dcache write-back to 0x0000123 with data 0x1111...11, then read 0x0000456 -> MAIN_MEM_WRITE with addr 0x0000123 and data 0x11..11, then a separate MAIN_MEM_READ with addr 0x0000456.
REQ-033 D_MEM_ADDRESS changed to 0x0000FFF during a grant at 0x0000001 -> MAIN_MEM_ADDRESS stays 0x0000001 until completion.
REQ-034 RESET_N pulled low in GRANT_D -> same cycle: MAIN_MEM_READ/WRITE=0 and both BUSY_WAIT=0; after release: IDLE, D_MEM_READ_DATA=0.
REQ-035 Two back-to-back I requests with the macro defined and D continuously requesting -> grants alternate I, D, I, D.
